jedro_1_bus_arbiter: RTL and testbench
======================================

# jedro_1_bus_arbiter

Two-master to one-slave bus arbiter placed between the jedro_1 core's instruction and data ports and a single unified `bytewrite_sram_wrap`. It lets the core run from one shared memory instance, as needed for the unified-memory riscof and FPGA builds. Requests are granted round-robin and presented downstream with zero added latency. Responses, which the slave returns in order, are routed back to the issuing port via a small ownership FIFO.

## Interface
- `DATA_WIDTH`, 32, request/response data width.
- `ADDR_WIDTH`, 32, request address width.
- `MAX_OUTSTANDING`, 2, ownership FIFO depth; power of two, ≥1.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `instr_req_{addr,data,strobe,write,valid}_i` / `instr_req_ready_o`: core instruction request. Widths are ADDR_WIDTH, DATA_WIDTH, 4, 1, 1 / 1.
- `instr_rsp_{data,error,valid}_o` / `instr_rsp_ready_i`: instruction response. Widths are DATA_WIDTH, 1, 1 / 1.
- `data_req_*_i` / `data_req_ready_o`: core data request; widths as for the instruction request.
- `data_rsp_*_o` / `data_rsp_ready_i`: data response; widths as for the instruction response.
- `mem_req_{addr,data,strobe,write,valid}_o` / `mem_req_ready_i`: request to the memory.
- `mem_rsp_{data,error,valid}_i` / `mem_rsp_ready_o`: response from the memory.

## Operation
- **Handshake:** a transfer occurs on any channel when valid && ready at a rising clock edge. Masters hold the request payload stable from valid until ready.
- **Grant selection:** when not locked, grant goes to the only valid requester. If both request, grant goes to the port not granted last (`last_grant`).
- **Request mux:** `mem_req_*` mirrors the granted port. The granted port's `*_req_ready_o` = `mem_req_ready_i && !fifo_full`. The other port's ready = 0.
- **FIFO full:** `mem_req_valid_o` = granted valid && `!fifo_full`. When full, no request is presented or accepted, even if a pop happens in the same cycle.
- **Lock:** set when `mem_req_valid_o && !mem_req_ready_i`. It freezes the grant so the downstream payload stays stable. It clears on the accepting handshake.
- **Accepted request:**
  - push the owner (INSTR/DATA) into the FIFO;
  - update `last_grant`.
- **Response routing:**
  - The owner at the FIFO head selects the destination: `<owner>_rsp_valid_o` = `mem_rsp_valid_i && !fifo_empty`. The other port's rsp_valid = 0.
  - data/error go to both ports unconditionally; they are qualified by valid.
  - `mem_rsp_ready_o` = head owner's `rsp_ready_i && !fifo_empty`.
  - A response handshake pops the FIFO.
- **Push and pop in the same cycle:** allowed when not full; the count is unchanged.
- **Response while FIFO empty:** protocol violation. `mem_rsp_ready_o` stays 0 and a simulation-only assertion fires.
- **Read-pointer wrap:** pointers wrap modulo MAX_OUTSTANDING. Count is $clog2(MAX_OUTSTANDING)+1 bits wide.

## Timing
- **Request path:** combinational, 0 cycles of added latency; the grant and lock registers only affect the next cycle.
- **Response path:** combinational, 0 cycles of added latency.
- **Reset:**
  - While `rstn_i`=0, all `*_valid_o` and `*_ready_o` = 0.
  - On reset: FIFO empty, lock=0, `last_grant`=DATA, so INSTR wins the first tie.
- **Reset mid-operation:** outstanding ownership entries are discarded. The memory is reset by the same `rstn_i`, so no orphan responses arise.
- **Throughput:** one request per cycle is sustained when the slave is always ready and MAX_OUTSTANDING ≥ slave latency + 1.

## Structure
- **Package `jedro_1_pkg`:** add typedef `bus_owner_e` (`OWNER_INSTR`=1'b0, `OWNER_DATA`=1'b1).
- **Sub-module `jedro_1_owner_fifo`:** synchronous 1-bit-wide FIFO, parameter DEPTH. Ports: push/pop/din/dout/full/empty, and it uses the same clock and reset.
- **Arbiter top:** holds the grant, lock and `last_grant` logic plus the combinational muxes.

## Test plan
- **Single requester:** instr-only reads 0x0, 0x4, 0x8 with the slave always ready. Expect three back-to-back accepts and responses routed only to instr. `data_rsp_valid_o` stays 0 throughout.
- **Tie:** both request in cycle 0, then stay valid. Expect grant sequence INSTR, DATA, INSTR, DATA, and responses returned to the matching ports in that order.
- **Lock:** DATA write to 0x100 with strobe 0xF, `mem_req_ready_i` held low for 3 cycles while instr also requests. Expect the mem payload to stay at 0x100 for all 4 cycles and `instr_req_ready_o`=0 throughout.
- **Full:** MAX_OUTSTANDING=2, slave stalls responses, three requests issued. Expect the third held with `req_ready`=0 until the first response handshake, then accepted one cycle later.
- **Back-pressure:** `data_rsp_ready_i`=0 for 2 cycles while the head owner is DATA. Expect `mem_rsp_ready_o`=0, no pop, and the following instr response not delivered until the data response has been delivered.
- **Reset:** `rstn_i` pulsed low with 2 requests outstanding. Expect all valid/ready outputs to go to 0 immediately. After release, FIFO empty and the first tie granted to INSTR.

Source files
------------

// File: rtl/jedro_1_pkg.sv
// Shared types for the jedro_1 bus fabric.
package jedro_1_pkg;

  // Which core port issued a memory request.
  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } bus_owner_e;

endpackage

// File: rtl/jedro_1_owner_fifo.sv
// 1-bit ownership FIFO: remembers which port owns each outstanding request.
module jedro_1_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  // Storage; stale entries are never read because empty gates the output users.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jedro_1_bus_arbiter.sv
// Round-robin arbiter: instr + data ports onto one in-order memory slave.
module jedro_1_bus_arbiter
  import jedro_1_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_WIDTH-1:0] instr_req_addr_i,
  input  logic [DATA_WIDTH-1:0] instr_req_data_i,
  input  logic [3:0]            instr_req_strobe_i,
  input  logic                  instr_req_write_i,
  input  logic                  instr_req_valid_i,
  output logic                  instr_req_ready_o,
  output logic [DATA_WIDTH-1:0] instr_rsp_data_o,
  output logic                  instr_rsp_error_o,
  output logic                  instr_rsp_valid_o,
  input  logic                  instr_rsp_ready_i,
  input  logic [ADDR_WIDTH-1:0] data_req_addr_i,
  input  logic [DATA_WIDTH-1:0] data_req_data_i,
  input  logic [3:0]            data_req_strobe_i,
  input  logic                  data_req_write_i,
  input  logic                  data_req_valid_i,
  output logic                  data_req_ready_o,
  output logic [DATA_WIDTH-1:0] data_rsp_data_o,
  output logic                  data_rsp_error_o,
  output logic                  data_rsp_valid_o,
  input  logic                  data_rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_data_o,
  output logic [3:0]            mem_req_strobe_o,
  output logic                  mem_req_write_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o
);

  bus_owner_e grant, grant_q, last_grant, head;
  logic       lock;
  logic       gnt_valid, req_rdy, accept;
  logic       fifo_full, fifo_empty, fifo_dout, rsp_pop;

  // Grant: frozen while a presented request waits, else round-robin on ties.
  always_comb begin
    grant = (last_grant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    if (lock) begin
      grant = grant_q;
    end else if (instr_req_valid_i && !data_req_valid_i) begin
      grant = OWNER_INSTR;
    end else if (data_req_valid_i && !instr_req_valid_i) begin
      grant = OWNER_DATA;
    end
  end

  // Request mux; all handshake outputs held low while in reset.
  always_comb begin
    gnt_valid         = (grant == OWNER_INSTR) ? instr_req_valid_i : data_req_valid_i;
    req_rdy           = rstn_i && mem_req_ready_i && !fifo_full;
    mem_req_valid_o   = rstn_i && gnt_valid && !fifo_full;
    instr_req_ready_o = (grant == OWNER_INSTR) && req_rdy;
    data_req_ready_o  = (grant == OWNER_DATA) && req_rdy;
    mem_req_addr_o    = (grant == OWNER_INSTR) ? instr_req_addr_i   : data_req_addr_i;
    mem_req_data_o    = (grant == OWNER_INSTR) ? instr_req_data_i   : data_req_data_i;
    mem_req_strobe_o  = (grant == OWNER_INSTR) ? instr_req_strobe_i : data_req_strobe_i;
    mem_req_write_o   = (grant == OWNER_INSTR) ? instr_req_write_i  : data_req_write_i;
    accept            = mem_req_valid_o && mem_req_ready_i;
  end

  // Grant/lock state: lock holds a stalled downstream payload stable.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock       <= 1'b0;
      grant_q    <= OWNER_INSTR;
      last_grant <= OWNER_DATA;
    end else begin
      lock    <= mem_req_valid_o && !mem_req_ready_i;
      grant_q <= grant;
      if (accept) last_grant <= grant;
    end
  end

  jedro_1_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (accept),
    .pop    (rsp_pop),
    .din    (logic'(grant)),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Response routing by the owner at the FIFO head; payload fans out to both.
  always_comb begin
    head              = bus_owner_e'(fifo_dout);
    instr_rsp_data_o  = mem_rsp_data_i;
    data_rsp_data_o   = mem_rsp_data_i;
    instr_rsp_error_o = mem_rsp_error_i;
    data_rsp_error_o  = mem_rsp_error_i;
    instr_rsp_valid_o = rstn_i && mem_rsp_valid_i && !fifo_empty && (head == OWNER_INSTR);
    data_rsp_valid_o  = rstn_i && mem_rsp_valid_i && !fifo_empty && (head == OWNER_DATA);
    mem_rsp_ready_o   = rstn_i && !fifo_empty &&
                        ((head == OWNER_INSTR) ? instr_rsp_ready_i : data_rsp_ready_i);
    rsp_pop           = mem_rsp_valid_i && mem_rsp_ready_o;
  end

  // A response with nothing outstanding means the slave broke protocol.
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(mem_rsp_valid_i && fifo_empty));

endmodule

// File: tb/tb_jedro_1_bus_arbiter.sv
// Bench for jedro_1_bus_arbiter: vector table, directed corners, random vs queue model.
module tb_jedro_1_bus_arbiter;
  localparam int MAXO = 2;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] i_addr = '0, i_data = '0, d_addr = '0, d_data = '0;
  logic [3:0]  i_strb = '0, d_strb = '0;
  logic        i_write = 1'b0, i_valid = 1'b0, d_write = 1'b0, d_valid = 1'b0;
  logic        irdy = 1'b1, drdy = 1'b1, mem_ready = 1'b1;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0, mem_rsp_valid = 1'b0;

  logic        instr_req_ready_o, data_req_ready_o, mem_req_valid_o, mem_req_write_o, mem_rsp_ready_o;
  logic [31:0] instr_rsp_data_o, data_rsp_data_o, mem_req_addr_o, mem_req_data_o;
  logic        instr_rsp_error_o, instr_rsp_valid_o, data_rsp_error_o, data_rsp_valid_o;
  logic [3:0]  mem_req_strobe_o;

  jedro_1_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .instr_req_addr_i(i_addr), .instr_req_data_i(i_data), .instr_req_strobe_i(i_strb),
    .instr_req_write_i(i_write), .instr_req_valid_i(i_valid), .instr_req_ready_o(instr_req_ready_o),
    .instr_rsp_data_o(instr_rsp_data_o), .instr_rsp_error_o(instr_rsp_error_o),
    .instr_rsp_valid_o(instr_rsp_valid_o), .instr_rsp_ready_i(irdy),
    .data_req_addr_i(d_addr), .data_req_data_i(d_data), .data_req_strobe_i(d_strb),
    .data_req_write_i(d_write), .data_req_valid_i(d_valid), .data_req_ready_o(data_req_ready_o),
    .data_rsp_data_o(data_rsp_data_o), .data_rsp_error_o(data_rsp_error_o),
    .data_rsp_valid_o(data_rsp_valid_o), .data_rsp_ready_i(drdy),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o), .mem_req_strobe_o(mem_req_strobe_o),
    .mem_req_write_o(mem_req_write_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_ready),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_error_i(mem_rsp_err), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_ready_o(mem_rsp_ready_o)
  );

  typedef struct { logic [31:0] d; logic e; } rsp_t;

  int checks = 0, errors = 0;
  // Reference state: owners outstanding, slave queue, per-port expected responses.
  int   mq[$];
  rsp_t sq[$], iq[$], dq[$];
  int   acc_log[$], rsp_log[$];
  int   m_last = 1, m_lockg = 0;
  bit   m_lock = 1'b0, rsp_en = 1'b0, iacc = 1'b0, dacc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t slave_fn(input logic [31:0] a, input logic [31:0] d, input logic w);
    rsp_t r;
    r.d = (a * 3) ^ d ^ 32'h1234_5678;
    r.e = w & a[3];
    return r;
  endfunction

  task automatic drive_rsp();
    mem_rsp_valid = rstn && rsp_en && (sq.size() > 0);
    mem_rsp_data  = (sq.size() > 0) ? sq[0].d : '0;
    mem_rsp_err   = (sq.size() > 0) ? sq[0].e : 1'b0;
  endtask

  // Compare every output with the rule-level model, then advance the model.
  task automatic model_check();
    int g, head;
    bit full, empty, gv, e_mv, e_ir, e_dr, e_mr;
    rsp_t r;
    iacc = 1'b0; dacc = 1'b0;
    if (!rstn) begin
      chk("rst_mem_req_valid", 32'(mem_req_valid_o), 0);
      chk("rst_instr_req_ready", 32'(instr_req_ready_o), 0);
      chk("rst_data_req_ready", 32'(data_req_ready_o), 0);
      chk("rst_instr_rsp_valid", 32'(instr_rsp_valid_o), 0);
      chk("rst_data_rsp_valid", 32'(data_rsp_valid_o), 0);
      chk("rst_mem_rsp_ready", 32'(mem_rsp_ready_o), 0);
      mq.delete(); sq.delete(); iq.delete(); dq.delete();
      m_last = 1; m_lock = 1'b0;
      return;
    end
    full  = (mq.size() == MAXO);
    empty = (mq.size() == 0);
    if (m_lock) g = m_lockg;
    else if (i_valid && !d_valid) g = 0;
    else if (d_valid && !i_valid) g = 1;
    else g = 1 - m_last;
    gv   = (g == 0) ? i_valid : d_valid;
    e_mv = gv && !full;
    chk("mem_req_valid", 32'(mem_req_valid_o), 32'(e_mv));
    if (i_valid) chk("instr_req_ready", 32'(instr_req_ready_o), 32'(g == 0 && mem_ready && !full));
    if (d_valid) chk("data_req_ready", 32'(data_req_ready_o), 32'(g == 1 && mem_ready && !full));
    if (e_mv) begin
      chk("mem_req_addr", mem_req_addr_o, (g == 0) ? i_addr : d_addr);
      chk("mem_req_data", mem_req_data_o, (g == 0) ? i_data : d_data);
      chk("mem_req_strobe", 32'(mem_req_strobe_o), 32'((g == 0) ? i_strb : d_strb));
      chk("mem_req_write", 32'(mem_req_write_o), 32'((g == 0) ? i_write : d_write));
    end
    head = empty ? -1 : mq[0];
    e_ir = mem_rsp_valid && head == 0;
    e_dr = mem_rsp_valid && head == 1;
    e_mr = !empty && ((head == 0) ? irdy : drdy);
    chk("instr_rsp_valid", 32'(instr_rsp_valid_o), 32'(e_ir));
    chk("data_rsp_valid", 32'(data_rsp_valid_o), 32'(e_dr));
    chk("mem_rsp_ready", 32'(mem_rsp_ready_o), 32'(e_mr));
    if (e_ir) begin
      chk("instr_rsp_pending", 32'(iq.size() > 0), 1);
      if (iq.size() > 0) begin
        chk("instr_rsp_data", instr_rsp_data_o, iq[0].d);
        chk("instr_rsp_error", 32'(instr_rsp_error_o), 32'(iq[0].e));
      end
    end
    if (e_dr) begin
      chk("data_rsp_pending", 32'(dq.size() > 0), 1);
      if (dq.size() > 0) begin
        chk("data_rsp_data", data_rsp_data_o, dq[0].d);
        chk("data_rsp_error", 32'(data_rsp_error_o), 32'(dq[0].e));
      end
    end
    if (mem_rsp_valid && e_mr) begin
      void'(mq.pop_front()); void'(sq.pop_front());
      if (head == 0 && iq.size() > 0) void'(iq.pop_front());
      if (head == 1 && dq.size() > 0) void'(dq.pop_front());
      rsp_log.push_back(head);
    end
    if (e_mv && mem_ready) begin
      r = (g == 0) ? slave_fn(i_addr, i_data, i_write) : slave_fn(d_addr, d_data, d_write);
      sq.push_back(r);
      if (g == 0) begin iq.push_back(r); iacc = 1'b1; end
      else begin dq.push_back(r); dacc = 1'b1; end
      mq.push_back(g); acc_log.push_back(g);
      m_last = g; m_lock = 1'b0;
    end else if (e_mv) begin
      m_lock = 1'b1; m_lockg = g;
    end else begin
      m_lock = 1'b0;
    end
  endtask

  // One clock: inputs were set at posedge+1, compared at negedge.
  task automatic step();
    drive_rsp();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0; d_valid = 1'b0; rsp_en = 1'b1; irdy = 1'b1; drdy = 1'b1;
    while (mq.size() > 0 && n < 20) begin step(); n++; end
    chk("drain_timeout", 32'(mq.size()), 0);
  endtask

  task automatic gen_i();
    i_valid = ($urandom_range(0, 3) != 0); i_addr = $urandom & 32'hFFFF_FFFC;
    i_data = $urandom; i_strb = 4'($urandom); i_write = 1'($urandom);
  endtask

  task automatic gen_d();
    d_valid = ($urandom_range(0, 3) != 0); d_addr = $urandom & 32'hFFFF_FFFC;
    d_data = $urandom; d_strb = 4'($urandom); d_write = 1'($urandom);
  endtask

  typedef struct { bit iv, dv, mrdy, e_mv, e_ir, e_dr; logic [31:0] e_addr; } vec_t;
  vec_t vt[6];
  int base, exp_acc[6];

  initial begin
    // Single-cycle vectors from a fresh reset (empty FIFO, INSTR wins ties).
    vt[0] = '{1, 0, 1, 1, 1, 0, 32'h10};
    vt[1] = '{0, 1, 1, 1, 0, 1, 32'h20};
    vt[2] = '{1, 1, 1, 1, 1, 0, 32'h10};
    vt[3] = '{1, 1, 0, 1, 0, 0, 32'h10};
    vt[4] = '{0, 0, 1, 0, 0, 0, 32'h0};
    vt[5] = '{0, 1, 0, 1, 0, 0, 32'h20};
    i_addr = 32'h10; d_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      i_valid = vt[k].iv; d_valid = vt[k].dv; mem_ready = vt[k].mrdy;
      #2;
      chk($sformatf("vec%0d_mem_valid", k), 32'(mem_req_valid_o), 32'(vt[k].e_mv));
      if (vt[k].e_mv) chk($sformatf("vec%0d_addr", k), mem_req_addr_o, vt[k].e_addr);
      if (vt[k].iv) chk($sformatf("vec%0d_iready", k), 32'(instr_req_ready_o), 32'(vt[k].e_ir));
      if (vt[k].dv) chk($sformatf("vec%0d_dready", k), 32'(data_req_ready_o), 32'(vt[k].e_dr));
      step();
    end

    // Single requester: three back-to-back instr reads.
    do_reset(); rsp_en = 1'b1; mem_ready = 1'b1; base = rsp_log.size();
    i_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_addr = 32'(4 * k);
      step();
      chk($sformatf("single_accept%0d", k), 32'(iacc), 1);
    end
    drain();
    chk("single_rsp_count", 32'(rsp_log.size() - base), 3);
    for (int k = base; k < rsp_log.size(); k++) chk("single_rsp_owner", 32'(rsp_log[k]), 0);

    // Tie: both always valid, grants alternate starting with INSTR.
    do_reset(); rsp_en = 1'b1; base = acc_log.size();
    i_valid = 1'b1; d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      i_addr = i_addr + 4; d_addr = d_addr + 8;
    end
    drain();
    chk("tie_accepts", 32'(acc_log.size() - base), 4);
    for (int k = 0; k < 4 && base + k < acc_log.size(); k++)
      chk($sformatf("tie_grant%0d", k), 32'(acc_log[base + k]), 32'(k % 2));

    // Lock: stalled DATA write keeps the downstream payload and starves instr.
    do_reset(); rsp_en = 1'b1;
    d_addr = 32'h100; d_strb = 4'hF; d_write = 1'b1; d_data = 32'hCAFE_0001; i_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      d_valid = 1'b1; i_valid = (k > 0); mem_ready = (k == 3);
      #2;
      chk("lock_addr", mem_req_addr_o, 32'h100);
      chk("lock_iready", 32'(instr_req_ready_o), 0);
      step();
    end
    d_valid = 1'b0; i_valid = 1'b0;
    drain();

    // Full: third request waits for the first response, then goes a cycle later.
    do_reset(); rsp_en = 1'b0; mem_ready = 1'b1;
    exp_acc = '{1, 1, 0, 0, 0, 1};
    i_valid = 1'b1; i_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      rsp_en = (k >= 4);
      step();
      chk($sformatf("full_accept%0d", k), 32'(iacc), 32'(exp_acc[k]));
      if (iacc) begin i_addr = i_addr + 4; i_valid = (k < 5); end
    end
    i_valid = 1'b0;
    drain();

    // Back-pressure on the DATA head blocks the later instr response.
    do_reset(); rsp_en = 1'b0; mem_ready = 1'b1; base = rsp_log.size();
    d_valid = 1'b1; d_addr = 32'h300; step();
    d_valid = 1'b0; i_valid = 1'b1; i_addr = 32'h304; step();
    i_valid = 1'b0; rsp_en = 1'b1; drdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_rsp(); #2;
      chk("bp_mem_rsp_ready", 32'(mem_rsp_ready_o), 0);
      chk("bp_instr_rsp_valid", 32'(instr_rsp_valid_o), 0);
      step();
    end
    drdy = 1'b1;
    drain();
    chk("bp_rsp_count", 32'(rsp_log.size() - base), 2);
    if (rsp_log.size() - base == 2) begin
      chk("bp_first_owner", 32'(rsp_log[base]), 1);
      chk("bp_second_owner", 32'(rsp_log[base + 1]), 0);
    end

    // Reset with two outstanding: outputs drop at once, then INSTR wins the tie.
    do_reset(); rsp_en = 1'b0; mem_ready = 1'b1;
    i_valid = 1'b1; i_addr = 32'h500; step();
    i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h504; step();
    i_valid = 1'b1; rsp_en = 1'b1; irdy = 1'b1;
    drive_rsp(); #1;
    chk("rst_pre_mem_rsp_ready", 32'(mem_rsp_ready_o), 1);
    rstn = 1'b0; #1;
    chk("rst_now_mem_req_valid", 32'(mem_req_valid_o), 0);
    chk("rst_now_instr_rsp_valid", 32'(instr_rsp_valid_o), 0);
    chk("rst_now_mem_rsp_ready", 32'(mem_rsp_ready_o), 0);
    chk("rst_now_data_req_ready", 32'(data_req_ready_o), 0);
    step();
    rstn = 1'b1; i_valid = 1'b1; d_valid = 1'b1;
    step();
    chk("rst_tie_instr", 32'(iacc), 1);
    drain();

    // Randomized traffic against the model.
    do_reset();
    gen_i(); gen_d();
    for (int k = 0; k < 600; k++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      rsp_en    = ($urandom_range(0, 9) < 7);
      irdy      = ($urandom_range(0, 4) != 0);
      drdy      = ($urandom_range(0, 4) != 0);
      step();
      if (iacc || !i_valid) gen_i();
      if (dacc || !d_valid) gen_d();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
